lag_local_inject_arbiter: RTL and testbench



---
 rtl/lag_local_inject_arbiter_pkg.sv | 18 +
 rtl/lag_rr_arbiter.sv | 38 +++
 rtl/lag_local_inject_arbiter.sv | 142 ++++++++++++++
 tb/tb_lag_local_inject_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_local_inject_arbiter_pkg.sv
// Shared types and defaults for the local injection arbiter and its round-robin core.
package lag_local_inject_arbiter_pkg;

    localparam int unsigned router_num_pls_on_entry = 2;

    localparam int unsigned LAG_NSRC   = 4;
    localparam int unsigned LAG_NPL    = router_num_pls_on_entry;
    localparam int unsigned LAG_FLIT_W = 64;
    localparam int unsigned LAG_CNT_W  = 32;

    typedef logic [LAG_FLIT_W-1:0] flit_t;

    // Bits needed to index n items; a single item still gets one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lag_rr_arbiter.sv
// Round-robin grant over N requests starting at ptr; produces the pointer for the next cycle.
module lag_rr_arbiter
    import lag_local_inject_arbiter_pkg::*;
#(
    parameter  int unsigned N  = LAG_NSRC,
    localparam int unsigned PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_c,
    output logic [PW-1:0] ptr_nxt_c
);

    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        gnt_c     = '0;
        idx       = '0;
        win       = '0;
        found     = 1'b0;
        ptr_nxt_c = ptr;
        for (int k = 0; k < int'(N); k++) begin
            idx = PW'((int'(ptr) + k) % int'(N));
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                win        = idx;
            end
        end
        if (advance && found) begin
            ptr_nxt_c = (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/lag_local_inject_arbiter.sv
// Shares one local injection port among NSRC sources: packet-granular lane allocation,
// round-robin flit interleaving, one-cycle registered output, statistics and protocol checking.
module lag_local_inject_arbiter
    import lag_local_inject_arbiter_pkg::*;
#(
    parameter int unsigned NSRC   = LAG_NSRC,
    parameter int unsigned NPL    = LAG_NPL,
    parameter int unsigned FLIT_W = LAG_FLIT_W,
    parameter int unsigned CNT_W  = LAG_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*FLIT_W-1:0] src_flit,
    input  logic [NSRC-1:0]        src_head,
    input  logic [NSRC-1:0]        src_tail,
    output logic [NSRC-1:0]        src_ready,
    input  logic [NPL-1:0]         lane_full,
    output logic                   inj_valid,
    output logic [FLIT_W-1:0]      inj_flit,
    output logic [NPL-1:0]         inj_lane,
    output logic [CNT_W-1:0]       pkt_count,
    output logic [CNT_W-1:0]       flit_count,
    output logic                   proto_err
);

    localparam int unsigned SW = idx_w(NSRC);
    localparam int unsigned LW = idx_w(NPL);

    logic [NPL-1:0]           lane_busy;
    logic [NPL-1:0][SW-1:0]   lane_owner;
    logic [NSRC-1:0]          src_holds;
    logic [NSRC-1:0][LW-1:0]  src_lane;
    logic [SW-1:0]            rr_ptr;

    logic [SW-1:0]     rr_ptr_nxt_c;
    logic [NSRC-1:0]   elig_c;
    logic [NSRC-1:0]   err_c;
    logic [NSRC-1:0]   gnt_c;
    logic              grant_c;
    logic              any_free_c;
    logic [LW-1:0]     free_lane_c;
    logic [SW-1:0]     win_c;
    logic              win_head_c;
    logic              win_tail_c;
    logic [LW-1:0]     win_lane_c;
    logic [FLIT_W-1:0] win_flit_c;

    // Lowest-index lane that is neither owned nor reported full by the router.
    always_comb begin
        any_free_c  = 1'b0;
        free_lane_c = '0;
        for (int l = int'(NPL) - 1; l >= 0; l--) begin
            if (!lane_busy[l] && !lane_full[l]) begin
                any_free_c  = 1'b1;
                free_lane_c = LW'(l);
            end
        end
    end

    // Body flits ride their owned lane; heads need a free lane; anything else is a violation.
    always_comb begin
        elig_c = '0;
        err_c  = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (src_valid[i]) begin
                if (src_holds[i]) begin
                    err_c[i]  = src_head[i];
                    elig_c[i] = !src_head[i] && !lane_full[src_lane[i]] &&
                                lane_busy[src_lane[i]] &&
                                (lane_owner[src_lane[i]] == SW'(i));
                end else begin
                    err_c[i]  = !src_head[i];
                    elig_c[i] = src_head[i] && any_free_c;
                end
            end
        end
    end

    assign grant_c   = |gnt_c;
    assign src_ready = gnt_c;

    lag_rr_arbiter #(
        .N (NSRC)
    ) u_rr (
        .req       (elig_c),
        .advance   (grant_c),
        .ptr       (rr_ptr),
        .gnt_c     (gnt_c),
        .ptr_nxt_c (rr_ptr_nxt_c)
    );

    always_comb begin
        win_c      = '0;
        win_head_c = 1'b0;
        win_tail_c = 1'b0;
        win_flit_c = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (gnt_c[i]) begin
                win_c      = SW'(i);
                win_head_c = src_head[i];
                win_tail_c = src_tail[i];
                win_flit_c = src_flit[i*FLIT_W +: FLIT_W];
            end
        end
        win_lane_c = win_head_c ? free_lane_c : src_lane[win_c];
    end

    // A tail grant leaves the lane free, so head+tail allocates and releases in one step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_busy  <= '0;
            lane_owner <= '0;
            src_holds  <= '0;
            src_lane   <= '0;
            rr_ptr     <= '0;
            inj_valid  <= 1'b0;
            inj_flit   <= '0;
            inj_lane   <= '0;
            pkt_count  <= '0;
            flit_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            rr_ptr    <= rr_ptr_nxt_c;
            inj_valid <= grant_c;
            proto_err <= proto_err | (|err_c);
            if (grant_c) begin
                inj_flit               <= win_flit_c;
                inj_lane               <= NPL'(1) << win_lane_c;
                lane_busy[win_lane_c]  <= !win_tail_c;
                lane_owner[win_lane_c] <= win_c;
                src_holds[win_c]       <= !win_tail_c;
                src_lane[win_c]        <= win_lane_c;
                flit_count             <= flit_count + CNT_W'(1);
                if (win_tail_c) begin
                    pkt_count <= pkt_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lag_local_inject_arbiter.sv
// Directed bench for lag_local_inject_arbiter with hand-computed grant and lane tables.
module tb_lag_local_inject_arbiter;

    localparam int unsigned NSRC   = 4;
    localparam int unsigned NPL    = 2;
    localparam int unsigned FLIT_W = 64;
    localparam int unsigned CNT_W  = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NSRC-1:0]        src_valid;
    logic [NSRC*FLIT_W-1:0] src_flit;
    logic [NSRC-1:0]        src_head;
    logic [NSRC-1:0]        src_tail;
    logic [NSRC-1:0]        src_ready;
    logic [NPL-1:0]         lane_full;
    logic                   inj_valid;
    logic [FLIT_W-1:0]      inj_flit;
    logic [NPL-1:0]         inj_lane;
    logic [CNT_W-1:0]       pkt_count;
    logic [CNT_W-1:0]       flit_count;
    logic                   proto_err;

    lag_local_inject_arbiter #(
        .NSRC(NSRC), .NPL(NPL), .FLIT_W(FLIT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_flit(src_flit), .src_head(src_head),
        .src_tail(src_tail), .src_ready(src_ready), .lane_full(lane_full),
        .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_lane(inj_lane),
        .pkt_count(pkt_count), .flit_count(flit_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Source model: each source sends one packet of ln flits from cycle st.
    int unsigned     st [NSRC];
    int unsigned     ln [NSRC];
    int unsigned     ps [NSRC];
    logic [NSRC-1:0] force_body;
    logic [NPL-1:0]  lf;
    int unsigned     cyc;

    logic [FLIT_W-1:0] exp_flit;
    logic [NPL-1:0]    exp_lane;
    int unsigned       exp_flits;
    int unsigned       exp_pkts;
    int                checks = 0;
    int                errors = 0;

    function automatic logic [FLIT_W-1:0] flit_of(input int unsigned i, input int unsigned p);
        return 64'hA5A5_0000_0000_0000 | (64'(i) << 16) | 64'(p);
    endfunction

    task automatic drive();
        for (int i = 0; i < int'(NSRC); i++) begin
            logic act;
            act = (cyc >= st[i]) && (ps[i] < ln[i]);
            src_valid[i] = act;
            src_head[i]  = act && (ps[i] == 0) && !force_body[i];
            src_tail[i]  = act && (ps[i] + 1 == ln[i]);
            src_flit[i*FLIT_W +: FLIT_W] = act ? flit_of(i, ps[i]) : '0;
        end
        lane_full = lf;
    endtask

    // Advance the source model along the expected grant of this cycle.
    task automatic take(input logic [NSRC-1:0] r, input logic [NPL-1:0] lane);
        for (int i = 0; i < int'(NSRC); i++) begin
            if (r[i]) begin
                exp_flit = flit_of(i, ps[i]);
                exp_lane = lane;
                exp_flits++;
                if (ps[i] + 1 == ln[i]) exp_pkts++;
                ps[i]++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            st[i] = 0; ln[i] = 0; ps[i] = 0;
        end
        force_body = '0;
        lf         = '0;
        cyc        = 0;
        drive();
        exp_flit  = '0;
        exp_lane  = '0;
        exp_flits = 0;
        exp_pkts  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (inj_valid !== 1'b0) begin errors++; $display("FAIL reset inj_valid got %b want 0", inj_valid); end
        checks++; if (inj_flit !== '0) begin errors++; $display("FAIL reset inj_flit got %h want 0", inj_flit); end
        checks++; if (inj_lane !== '0) begin errors++; $display("FAIL reset inj_lane got %b want 00", inj_lane); end
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL reset pkt_count got %0d want 0", pkt_count); end
        checks++; if (flit_count !== '0) begin errors++; $display("FAIL reset flit_count got %0d want 0", flit_count); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset proto_err got %b want 0", proto_err); end
        checks++; if (src_ready !== '0) begin errors++; $display("FAIL reset src_ready got %b want 0000", src_ready); end
    endtask

    task automatic test_single_packet();
        logic [NSRC-1:0] er [6];
        logic [NPL-1:0]  el [6];
        er = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h0};
        el = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        do_reset();
        st[0] = 0; ln[0] = 4;
        st[1] = 4; ln[1] = 1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (inj_valid !== (er[c-1] != 0)) begin errors++; $display("FAIL single inj_valid c%0d got %b", c, inj_valid); end
                checks++; if (inj_lane !== exp_lane) begin errors++; $display("FAIL single inj_lane c%0d got %b want %b", c, inj_lane, exp_lane); end
                checks++; if (inj_flit !== exp_flit) begin errors++; $display("FAIL single inj_flit c%0d got %h want %h", c, inj_flit, exp_flit); end
            end
            if (c == 4) begin
                checks++; if (pkt_count !== 32'd1 || flit_count !== 32'd4) begin
                    errors++; $display("FAIL single counters got pkt=%0d flit=%0d want 1/4", pkt_count, flit_count);
                end
            end
            if (c < 6) begin
                drive(); #1;
                checks++; if (src_ready !== er[c]) begin errors++; $display("FAIL single src_ready c%0d got %b want %b", c, src_ready, er[c]); end
                @(posedge clk); #1;
                take(er[c], el[c]);
            end
        end
        checks++; if (pkt_count !== CNT_W'(exp_pkts)) begin errors++; $display("FAIL single pkt_count got %0d want %0d", pkt_count, exp_pkts); end
        checks++; if (flit_count !== CNT_W'(exp_flits)) begin errors++; $display("FAIL single flit_count got %0d want %0d", flit_count, exp_flits); end
    endtask

    task automatic test_interleave();
        logic [NSRC-1:0] er [7];
        logic [NPL-1:0]  el [7];
        er = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h0};
        el = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        do_reset();
        st[0] = 0; ln[0] = 3;
        st[1] = 0; ln[1] = 3;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (inj_valid !== (er[c-1] != 0)) begin errors++; $display("FAIL interleave inj_valid c%0d got %b", c, inj_valid); end
                checks++; if (inj_lane !== exp_lane) begin errors++; $display("FAIL interleave inj_lane c%0d got %b want %b", c, inj_lane, exp_lane); end
                checks++; if (inj_flit !== exp_flit) begin errors++; $display("FAIL interleave inj_flit c%0d got %h want %h", c, inj_flit, exp_flit); end
            end
            if (c < 7) begin
                drive(); #1;
                checks++; if (src_ready !== er[c]) begin errors++; $display("FAIL interleave src_ready c%0d got %b want %b", c, src_ready, er[c]); end
                @(posedge clk); #1;
                take(er[c], el[c]);
            end
        end
        checks++; if (pkt_count !== CNT_W'(exp_pkts) || flit_count !== CNT_W'(exp_flits)) begin
            errors++; $display("FAIL interleave counters got pkt=%0d flit=%0d want %0d/%0d", pkt_count, flit_count, exp_pkts, exp_flits);
        end
    endtask

    task automatic test_lane_exhaust();
        logic [NSRC-1:0] er [7];
        logic [NPL-1:0]  el [7];
        er = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h4, 4'h4, 4'h0};
        el = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            st[i] = 0; ln[i] = 2;
        end
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (inj_valid !== (er[c-1] != 0)) begin errors++; $display("FAIL exhaust inj_valid c%0d got %b", c, inj_valid); end
                checks++; if (inj_lane !== exp_lane) begin errors++; $display("FAIL exhaust inj_lane c%0d got %b want %b", c, inj_lane, exp_lane); end
                checks++; if (inj_flit !== exp_flit) begin errors++; $display("FAIL exhaust inj_flit c%0d got %h want %h", c, inj_flit, exp_flit); end
            end
            if (c < 7) begin
                drive(); #1;
                checks++; if (src_ready !== er[c]) begin errors++; $display("FAIL exhaust src_ready c%0d got %b want %b", c, src_ready, er[c]); end
                @(posedge clk); #1;
                take(er[c], el[c]);
            end
        end
        checks++; if (pkt_count !== 32'd3 || flit_count !== 32'd6) begin
            errors++; $display("FAIL exhaust counters got pkt=%0d flit=%0d want 3/6", pkt_count, flit_count);
        end
    endtask

    task automatic test_lane_full();
        logic [NSRC-1:0] er [13];
        logic [NPL-1:0]  el [13];
        er = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        el = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        do_reset();
        st[0] = 0; ln[0] = 6;
        st[1] = 0; ln[1] = 6;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (inj_valid !== (er[c-1] != 0)) begin errors++; $display("FAIL full inj_valid c%0d got %b", c, inj_valid); end
                checks++; if (inj_lane !== exp_lane) begin errors++; $display("FAIL full inj_lane c%0d got %b want %b", c, inj_lane, exp_lane); end
                checks++; if (inj_flit !== exp_flit) begin errors++; $display("FAIL full inj_flit c%0d got %h want %h", c, inj_flit, exp_flit); end
            end
            if (c < 13) begin
                lf = (c >= 2 && c <= 5) ? 2'b01 : 2'b00;
                drive(); #1;
                checks++; if (src_ready !== er[c]) begin errors++; $display("FAIL full src_ready c%0d got %b want %b", c, src_ready, er[c]); end
                @(posedge clk); #1;
                take(er[c], el[c]);
            end
        end
        lf = '0;
        checks++; if (pkt_count !== 32'd2 || flit_count !== 32'd12) begin
            errors++; $display("FAIL full counters got pkt=%0d flit=%0d want 2/12", pkt_count, flit_count);
        end
    endtask

    task automatic test_proto_err();
        logic [NSRC-1:0] er [4];
        logic [NPL-1:0]  el [4];
        er = '{4'h1, 4'h1, 4'h0, 4'h0};
        el = '{2'b01, 2'b01, 2'b00, 2'b00};
        do_reset();
        st[0] = 0; ln[0] = 2;
        st[3] = 0; ln[3] = 1000; force_body[3] = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (proto_err !== (c > 0)) begin errors++; $display("FAIL proto proto_err c%0d got %b want %b", c, proto_err, c > 0); end
            if (c > 0) begin
                checks++; if (inj_valid !== (er[c-1] != 0)) begin errors++; $display("FAIL proto inj_valid c%0d got %b", c, inj_valid); end
                checks++; if (inj_lane !== exp_lane) begin errors++; $display("FAIL proto inj_lane c%0d got %b want %b", c, inj_lane, exp_lane); end
            end
            if (c < 4) begin
                drive(); #1;
                checks++; if (src_ready !== er[c]) begin errors++; $display("FAIL proto src_ready c%0d got %b want %b", c, src_ready, er[c]); end
                @(posedge clk); #1;
                take(er[c], el[c]);
            end
        end
        ln[3] = 0;
        drive();
        repeat (2) @(negedge clk);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto sticky got %b want 1", proto_err); end
        checks++; if (flit_count !== 32'd2 || pkt_count !== 32'd1) begin
            errors++; $display("FAIL proto counters got pkt=%0d flit=%0d want 1/2", pkt_count, flit_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [NSRC-1:0] er [2];
        logic [NPL-1:0]  el [2];
        er = '{4'h1, 4'h1};
        el = '{2'b01, 2'b01};
        do_reset();
        st[0] = 0; ln[0] = 4;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (inj_valid !== 1'b1 || inj_flit !== exp_flit) begin
                    errors++; $display("FAIL midrst pre inj c%0d got %b/%h want 1/%h", c, inj_valid, inj_flit, exp_flit);
                end
            end
            if (c < 2) begin
                drive(); #1;
                checks++; if (src_ready !== er[c]) begin errors++; $display("FAIL midrst src_ready c%0d got %b want %b", c, src_ready, er[c]); end
                @(posedge clk); #1;
                take(er[c], el[c]);
            end
        end
        rst_n = 1'b0;
        ln[0] = 0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (inj_valid !== 1'b0 || inj_flit !== '0 || inj_lane !== '0) begin
            errors++; $display("FAIL midrst outputs got v=%b f=%h l=%b want 0/0/0", inj_valid, inj_flit, inj_lane);
        end
        checks++; if (pkt_count !== '0 || flit_count !== '0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL midrst state got pkt=%0d flit=%0d err=%b want 0/0/0", pkt_count, flit_count, proto_err);
        end
        cyc = 0; st[1] = 0; ps[1] = 0; ln[1] = 1;
        drive(); #1;
        checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL midrst fresh src_ready got %b want 0010", src_ready); end
        @(posedge clk); #1;
        ln[1] = 0;
        @(negedge clk);
        drive();
        checks++; if (inj_valid !== 1'b1 || inj_lane !== 2'b01 || inj_flit !== flit_of(1, 0)) begin
            errors++; $display("FAIL midrst fresh inj got v=%b l=%b f=%h want 1/01/%h", inj_valid, inj_lane, inj_flit, flit_of(1, 0));
        end
    endtask

    initial begin
        src_valid  = '0;
        src_flit   = '0;
        src_head   = '0;
        src_tail   = '0;
        lane_full  = '0;
        force_body = '0;
        lf         = '0;
        cyc        = 0;
        test_reset();
        test_single_packet();
        test_interleave();
        test_lane_exhaust();
        test_lane_full();
        test_proto_err();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
